// File: rtl/adventure_game_if.sv
// Board-side bundle for the adventure game: direction buttons in, room/status LEDs out.
// The master drives the buttons and watches the status; the game block is the slave.
interface adventure_game_if #(
    parameter int LIVES     = 3,
    parameter int DRAGON_HP = 2,
    parameter int MOVE_W    = 8
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int HW = $clog2(DRAGON_HP + 1);

    logic              n;
    logic              s;
    logic              e;
    logic              w;
    logic [6:0]        room;
    logic              sw;
    logic              win;
    logic              d;
    logic              game_over;
    logic [LW-1:0]     lives;
    logic [HW-1:0]     dragon_hp;
    logic [MOVE_W-1:0] moves;

    modport master (
        output n, s, e, w,
        input  room, sw, win, d, game_over, lives, dragon_hp, moves
    );

    modport slave (
        input  n, s, e, w,
        output room, sw, win, d, game_over, lives, dragon_hp, moves
    );
endinterface

// File: rtl/adventure_game.sv
// One-hot room FSM for the adventure lab: map, sword, multi-hit dragon fight,
// lives with respawn and a saturating move counter, all held in registers.
module adventure_game #(
    parameter int LIVES     = 3,
    parameter int DRAGON_HP = 2,
    parameter int MOVE_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    adventure_game_if.slave game
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int HW = $clog2(DRAGON_HP + 1);

    typedef enum logic [6:0] {
        CAVE    = 7'b0000001,
        TUNNEL  = 7'b0000010,
        RIVER   = 7'b0000100,
        STASH   = 7'b0001000,
        DEN     = 7'b0010000,
        VICTORY = 7'b0100000,
        DEATH   = 7'b1000000
    } room_t;

    room_t             state;
    room_t             target;
    logic              move_ok;
    logic              sword;
    logic              over;
    logic [LW-1:0]     lives_left;
    logic [HW-1:0]     hp_left;
    logic [MOVE_W-1:0] move_count;
    logic [3:0]        buttons;

    assign buttons = {game.n, game.s, game.e, game.w};

    // Exit table for the walkable rooms; only single-button presses count.
    always_comb begin
        move_ok = 1'b0;
        target  = state;
        if ($onehot(buttons)) begin
            case (state)
                CAVE: begin
                    if (game.e) begin
                        target  = TUNNEL;
                        move_ok = 1'b1;
                    end
                end
                TUNNEL: begin
                    if (game.w) begin
                        target  = CAVE;
                        move_ok = 1'b1;
                    end else if (game.s) begin
                        target  = RIVER;
                        move_ok = 1'b1;
                    end
                end
                RIVER: begin
                    if (game.n) begin
                        target  = TUNNEL;
                        move_ok = 1'b1;
                    end else if (game.w) begin
                        target  = STASH;
                        move_ok = 1'b1;
                    end else if (game.e) begin
                        target  = DEN;
                        move_ok = 1'b1;
                    end
                end
                STASH: begin
                    if (game.e) begin
                        target  = RIVER;
                        move_ok = 1'b1;
                    end
                end
                default: begin
                    move_ok = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CAVE;
            sword      <= 1'b0;
            over       <= 1'b0;
            lives_left <= LW'(LIVES);
            hp_left    <= HW'(DRAGON_HP);
            move_count <= '0;
        end else begin
            case (state)
                CAVE, TUNNEL, RIVER, STASH: begin
                    if (move_ok) begin
                        state <= target;
                        if (move_count != '1) begin
                            move_count <= move_count + 1'b1;
                        end
                        if (target == STASH) begin
                            sword <= 1'b1;
                        end
                    end
                end
                DEN: begin
                    if (sword) begin
                        if (hp_left <= HW'(1)) begin
                            hp_left <= '0;
                            state   <= VICTORY;
                        end else begin
                            hp_left <= hp_left - 1'b1;
                        end
                    end else begin
                        state <= DEATH;
                        // The last life makes Death terminal on this same edge.
                        if (lives_left <= LW'(1)) begin
                            lives_left <= '0;
                            over       <= 1'b1;
                        end else begin
                            lives_left <= lives_left - 1'b1;
                        end
                    end
                end
                VICTORY: begin
                    state <= VICTORY;
                end
                DEATH: begin
                    if (!over) begin
                        state   <= CAVE;
                        sword   <= 1'b0;
                        hp_left <= HW'(DRAGON_HP);
                    end
                end
                default: begin
                    state <= CAVE;
                end
            endcase
        end
    end

    assign game.room      = state;
    assign game.sw        = sword;
    assign game.win       = state[5];
    assign game.d         = state[6];
    assign game.game_over = over;
    assign game.lives     = lives_left;
    assign game.dragon_hp = hp_left;
    assign game.moves     = move_count;
endmodule

// File: tb/tb_adventure_game.sv
// Directed bench for adventure_game: a default-size instance plus a 2-bit move
// counter instance, both fed the same buttons and checked against hand values.
module tb_adventure_game;
    logic clk;
    logic reset;
    int   check_count;
    int   fail_count;

    adventure_game_if #(.LIVES(3), .DRAGON_HP(2), .MOVE_W(8)) gi ();
    adventure_game_if #(.LIVES(3), .DRAGON_HP(2), .MOVE_W(2)) gi2 ();

    adventure_game #(.LIVES(3), .DRAGON_HP(2), .MOVE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .game  (gi)
    );

    adventure_game #(.LIVES(3), .DRAGON_HP(2), .MOVE_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .game  (gi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Buttons are {n,s,e,w}; held for the given number of edges, then released.
    task automatic applyStimulus(input logic [3:0] buttons, input int cycles);
        {gi.n, gi.s, gi.e, gi.w}     = buttons;
        {gi2.n, gi2.s, gi2.e, gi2.w} = buttons;
        repeat (cycles) @(posedge clk);
        #1;
        {gi.n, gi.s, gi.e, gi.w}     = 4'b0000;
        {gi2.n, gi2.s, gi2.e, gi2.w} = 4'b0000;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    localparam logic [3:0] BN = 4'b1000;
    localparam logic [3:0] BS = 4'b0100;
    localparam logic [3:0] BE = 4'b0010;
    localparam logic [3:0] BW = 4'b0001;

    initial begin
        check_count = 0;
        fail_count  = 0;
        {gi.n, gi.s, gi.e, gi.w}     = 4'b0000;
        {gi2.n, gi2.s, gi2.e, gi2.w} = 4'b0000;
        doReset();
        #1;
        checkOutput("rst_room", 32'(gi.room), 32'd1);
        checkOutput("rst_sw", 32'(gi.sw), 32'd0);
        checkOutput("rst_win", 32'(gi.win), 32'd0);
        checkOutput("rst_d", 32'(gi.d), 32'd0);
        checkOutput("rst_over", 32'(gi.game_over), 32'd0);
        checkOutput("rst_lives", 32'(gi.lives), 32'd3);
        checkOutput("rst_hp", 32'(gi.dragon_hp), 32'd2);
        checkOutput("rst_moves", 32'(gi.moves), 32'd0);

        // Sword run to victory.
        applyStimulus(BE, 1);
        checkOutput("win_tunnel", 32'(gi.room), 32'd2);
        applyStimulus(BS, 1);
        checkOutput("win_river", 32'(gi.room), 32'd4);
        applyStimulus(BW, 1);
        checkOutput("win_stash", 32'(gi.room), 32'd8);
        checkOutput("win_sw", 32'(gi.sw), 32'd1);
        applyStimulus(BE, 1);
        checkOutput("win_river2", 32'(gi.room), 32'd4);
        applyStimulus(BE, 1);
        checkOutput("win_den", 32'(gi.room), 32'd16);
        checkOutput("win_moves", 32'(gi.moves), 32'd5);
        applyStimulus(4'b0000, 1);
        checkOutput("fight_room", 32'(gi.room), 32'd16);
        checkOutput("fight_hp", 32'(gi.dragon_hp), 32'd1);
        applyStimulus(BN, 1);
        checkOutput("victory_room", 32'(gi.room), 32'd32);
        checkOutput("victory_win", 32'(gi.win), 32'd1);
        checkOutput("victory_hp", 32'(gi.dragon_hp), 32'd0);
        applyStimulus(BW, 3);
        checkOutput("victory_hold", 32'(gi.room), 32'd32);
        checkOutput("victory_moves", 32'(gi.moves), 32'd5);
        checkOutput("victory_lives", 32'(gi.lives), 32'd3);

        // Three unarmed dragon visits exhaust the lives.
        doReset();
        for (int life = 1; life <= 3; life++) begin
            applyStimulus(BE, 1);
            applyStimulus(BS, 1);
            applyStimulus(BE, 1);
            checkOutput("die_den", 32'(gi.room), 32'd16);
            applyStimulus(4'b0000, 1);
            checkOutput("die_d", 32'(gi.d), 32'd1);
            checkOutput("die_lives", 32'(gi.lives), 32'(3 - life));
            checkOutput("die_hp", 32'(gi.dragon_hp), 32'd2);
            checkOutput("die_over", 32'(gi.game_over), (life == 3) ? 32'd1 : 32'd0);
            if (life < 3) begin
                applyStimulus(4'b0000, 1);
                checkOutput("respawn_room", 32'(gi.room), 32'd1);
                checkOutput("respawn_sw", 32'(gi.sw), 32'd0);
                checkOutput("respawn_hp", 32'(gi.dragon_hp), 32'd2);
                checkOutput("respawn_moves", 32'(gi.moves), 32'(3 * life));
            end
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1);
        end
        checkOutput("over_room", 32'(gi.room), 32'd64);
        checkOutput("over_flag", 32'(gi.game_over), 32'd1);
        checkOutput("over_lives", 32'(gi.lives), 32'd0);
        checkOutput("over_moves", 32'(gi.moves), 32'd9);

        // Ignored requests, then a held east press.
        doReset();
        applyStimulus(BN | BE, 1);
        checkOutput("multi_room", 32'(gi.room), 32'd1);
        applyStimulus(4'b0000, 1);
        checkOutput("none_room", 32'(gi.room), 32'd1);
        applyStimulus(BW, 1);
        checkOutput("noexit_room", 32'(gi.room), 32'd1);
        checkOutput("ignored_moves", 32'(gi.moves), 32'd0);
        applyStimulus(BE, 3);
        checkOutput("held_room", 32'(gi.room), 32'd2);
        checkOutput("held_moves", 32'(gi.moves), 32'd1);

        // Move counter saturation on the 2-bit instance.
        doReset();
        applyStimulus(BE, 1);
        applyStimulus(BW, 1);
        checkOutput("sat_two", 32'(gi2.moves), 32'd2);
        applyStimulus(BE, 1);
        checkOutput("sat_three", 32'(gi2.moves), 32'd3);
        applyStimulus(BW, 1);
        applyStimulus(BE, 1);
        applyStimulus(BW, 1);
        checkOutput("sat_hold", 32'(gi2.moves), 32'd3);
        checkOutput("sat_room", 32'(gi2.room), 32'd1);
        checkOutput("wide_moves", 32'(gi.moves), 32'd6);

        // Asynchronous reset in the middle of the dragon fight.
        doReset();
        applyStimulus(BE, 1);
        applyStimulus(BS, 1);
        applyStimulus(BW, 1);
        applyStimulus(BE, 1);
        applyStimulus(BE, 1);
        applyStimulus(4'b0000, 1);
        checkOutput("mid_hp", 32'(gi.dragon_hp), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_room", 32'(gi.room), 32'd1);
        checkOutput("async_hp", 32'(gi.dragon_hp), 32'd2);
        checkOutput("async_sw", 32'(gi.sw), 32'd0);
        checkOutput("async_moves", 32'(gi.moves), 32'd0);
        #1;
        reset = 1'b0;
        applyStimulus(4'b0000, 2);
        checkOutput("after_room", 32'(gi.room), 32'd1);
        checkOutput("after_win", 32'(gi.win), 32'd0);
        applyStimulus(BE, 1);
        checkOutput("first_move", 32'(gi.room), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end
endmodule
